regfile_mul_issue: RTL and testbench
====================================

Name: regfile_mul_issue

Overview:
- Small architectural register file plus single-issue execute stage.
- Accepts micro-ops (write-immediate, add, multiply) over a valid/ready command channel and reads both source operands from the register file.
- Executes multiplies on a sequential shift-add datapath, then writes the result back.
- Exposes the latched operands and the result (op_a, op_b, res_x). The downstream smtlib2 multiply/add constraint check consumes them as its a, b, x.

Parameters:
DATA_W, 8, register and operand width in bits
NREGS, 8, number of architectural registers (power of two, >= 2)
AW, $clog2(NREGS), register index width (derived, not overridable)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  stage can accept a command
cmd_op  input  2  0=WRI (rd=imm), 1=ADD, 2=MUL, 3=reserved (treated as NOP)
cmd_rd  input  AW  destination register
cmd_rs1  input  AW  source register 1
cmd_rs2  input  AW  source register 2
cmd_imm  input  DATA_W  immediate for WRI
dbg_addr  input  AW  debug read index
dbg_data  output  DATA_W  combinational read of regs[dbg_addr]
done  output  1  one-cycle pulse: write-back occurring this cycle
done_rd  output  AW  destination of the completing op
op_a  output  DATA_W  latched operand 1
op_b  output  DATA_W  latched operand 2
res_x  output  DATA_W  result being written back (valid when done=1)

Behaviour:
- Reset (async assert, sync release): all registers 0, state IDLE.
- Reset values: cmd_ready=1, done=0, done_rd=0, op_a=0, op_b=0, res_x=0, multiplier accumulator/counter 0.
- r0 is hardwired: reads return 0; writes are dropped, but done still pulses.
- FSM states IDLE, MUL, WB. cmd_ready = (state==IDLE). Accept = cmd_valid && cmd_ready.
- On accept:
  - Latch op_a=regs[rs1], op_b=regs[rs2] (WRI: op_a=imm, op_b=0), plus rd and op.
  - MUL goes to MUL; all other ops go to WB.
- MUL:
  - Iterate DATA_W cycles, one multiplier bit per cycle, LSB first.
  - acc += (mcand << i) when op_b[i]; keep only the low DATA_W bits.
  - After the DATA_W-th iteration, go to WB.
- Results:
  - res_x = low DATA_W bits of op_a*op_b (MUL), op_a+op_b mod 2^DATA_W (ADD), op_a (WRI), 0 for NOP.
- WB lasts exactly one cycle:
  - done=1, done_rd=rd, res_x stable.
  - regs[rd] updated at the closing edge (unless rd==0 or NOP).
  - Next state IDLE.
- Latency, with accept at edge E:
  - WRI/ADD/NOP: done during the cycle after E.
  - MUL: done during cycle E+DATA_W+1 (9 cycles after accept for DATA_W=8).
  - cmd_ready returns 1 the cycle after WB.
- Back-to-back: no bypass is needed. Operands are latched at accept and the next command can only be accepted after write-back has landed.
- rs1==rs2==rd is legal; operands use pre-write values.
- dbg_data shows the old value during WB and the new value from the following cycle.
- op_a/op_b hold their values from accept until the next accept. res_x holds after WB.
- cmd_* fields are ignored when cmd_ready=0. A held cmd_valid is accepted on the first cycle ready is high.
- Reset asserted mid-MUL or mid-WB:
  - Immediate abort, no register write, no done pulse.
  - All state returns to reset values.

Decomposition:
- Shared package regfile_pkg: op-code enum (OP_WRI, OP_ADD, OP_MUL, OP_NOP), FSM state enum, DATA_W/NREGS defaults.
- One sub-module, seq_mul: start, a, b → busy, done, product (low DATA_W bits), DATA_W-cycle shift-add, async active-low reset.
- Register array and FSM stay in the top module.

Test Plan:
- WRI r1=7, WRI r2=6, MUL r3=r1*r2 → done 9 cycles after MUL accept with done_rd=3, res_x=42, op_a=7, op_b=6; dbg r3=42 the next cycle.
- WRI r1=0xFF, MUL r4=r1*r1 → res_x=0x01 (truncated 0xFE01); ADD r5=0xF0(r6)+0x20(r7) → res_x=0x10 (wrap).
- WRI r0=0x55 → done=1 with done_rd=0, dbg r0 reads 0; subsequent ADD r1=r0+r0 → res_x=0.
- cmd_valid held high with three queued ops → cmd_ready low throughout MUL/WB, each op accepted exactly once, in order, with correct latencies.
- MUL r3=r1*r2, rst_n pulsed low at cycle 4 of MUL → no done pulse, cmd_ready=1, all registers read 0 after release.
- MUL r2=r2*r2 with r2=5 → res_x=25, r2=25 after WB; cmd_op=3 → done pulse one cycle after accept, no register changes.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register file / issue stage.
package regfile_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NREGS  = 8;

    typedef enum logic [1:0] {
        OP_WRI = 2'd0,
        OP_ADD = 2'd1,
        OP_MUL = 2'd2,
        OP_NOP = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first,
// product truncated to W bits. done flags the cycle whose closing edge
// commits the final partial product, so product is complete right after it.
module seq_mul #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;

    // Load operands on start, then add/shift once per cycle until the counter expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= CW'(W);
            busy   <= 1'b1;
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign done    = busy && (cnt == CW'(1));
    assign product = acc;

endmodule

// File: rtl/regfile_mul_issue.sv
// Architectural register file with a single-issue execute stage (WRI/ADD/MUL).
// r0 reads as zero and is never written. Operands are latched at accept,
// so no bypassing is needed between consecutive commands.
module regfile_mul_issue
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [AW-1:0]     cmd_rd,
    input  logic [AW-1:0]     cmd_rs1,
    input  logic [AW-1:0]     cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              done,
    output logic [AW-1:0]     done_rd,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] res_x
);

    logic [DATA_W-1:0] regs [NREGS];
    state_t            state;
    op_t               op_q;
    op_t               cmd_op_e;
    logic [AW-1:0]     rd_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] alu_nxt;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic              accept;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    assign cmd_op_e = op_t'(cmd_op);
    assign accept   = cmd_valid && cmd_ready;
    assign rs1_val  = (cmd_rs1 == '0) ? '0 : regs[cmd_rs1];
    assign rs2_val  = (cmd_rs2 == '0) ? '0 : regs[cmd_rs2];
    assign opnd_a   = (cmd_op_e == OP_WRI) ? cmd_imm : rs1_val;
    assign opnd_b   = (cmd_op_e == OP_WRI) ? '0 : rs2_val;
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
    assign done_rd  = rd_q;
    assign res_x    = (op_q == OP_MUL) ? mul_product : alu_q;

    // Single-cycle result for non-multiply ops, captured at accept.
    always_comb begin
        alu_nxt = '0;
        case (cmd_op_e)
            OP_WRI:  alu_nxt = opnd_a;
            OP_ADD:  alu_nxt = opnd_a + opnd_b;
            default: alu_nxt = '0;
        endcase
    end

    seq_mul #(.W(DATA_W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && (cmd_op_e == OP_MUL)),
        .a       (opnd_a),
        .b       (opnd_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Issue FSM: accept in IDLE, wait out the multiplier, one-cycle write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
            op_q      <= OP_NOP;
            rd_q      <= '0;
            op_a      <= '0;
            op_b      <= '0;
            alu_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= cmd_op_e;
                        rd_q      <= cmd_rd;
                        op_a      <= opnd_a;
                        op_b      <= opnd_b;
                        alu_q     <= alu_nxt;
                        cmd_ready <= 1'b0;
                        if (cmd_op_e == OP_MUL) begin
                            state <= ST_MUL;
                        end else begin
                            state <= ST_WB;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_busy && mul_done) begin
                        state <= ST_WB;
                        done  <= 1'b1;
                    end
                end
                ST_WB: begin
                    state     <= ST_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    // Register write-back at the edge closing the WB cycle; r0 and NOP never write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if ((state == ST_WB) && (op_q != OP_NOP) && (rd_q != '0)) begin
            regs[rd_q] <= res_x;
        end
    end

endmodule

// File: tb/tb_regfile_mul_issue.sv
// Directed bench for regfile_mul_issue: inputs driven and outputs sampled on
// the falling edge; expected values are hand-computed constants.
module tb_regfile_mul_issue;

    localparam int DATA_W = 8;
    localparam int NREGS  = 8;
    localparam int AW     = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [AW-1:0]     cmd_rd = '0;
    logic [AW-1:0]     cmd_rs1 = '0;
    logic [AW-1:0]     cmd_rs2 = '0;
    logic [DATA_W-1:0] cmd_imm = '0;
    logic [AW-1:0]     dbg_addr = '0;
    logic [DATA_W-1:0] dbg_data;
    logic              done;
    logic [AW-1:0]     done_rd;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] res_x;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_mul_issue #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_imm   (cmd_imm),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .done      (done),
        .done_rd   (done_rd),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_x     (res_x)
    );

    // Waits for ready, presents one command for exactly one accepting edge.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic [DATA_W-1:0] imm);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_imm   = imm;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Returns the cycle index (1 = cycle right after accept) at which done is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors += 6;
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
        if (done_rd !== 3'd0) begin miscompares++; $display("FAIL rst_done_rd: got %0d want 0", done_rd); end
        if (op_a !== 8'h00) begin miscompares++; $display("FAIL rst_op_a: got %h want 00", op_a); end
        if (op_b !== 8'h00) begin miscompares++; $display("FAIL rst_op_b: got %h want 00", op_b); end
        if (res_x !== 8'h00) begin miscompares++; $display("FAIL rst_res_x: got %h want 00", res_x); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul_basic();
        int lat;
        issue(2'd0, 3'd1, 3'd0, 3'd0, 8'd7);
        wait_done(lat);
        vectors += 3;
        if (lat != 1) begin miscompares++; $display("FAIL wri_latency: got %0d want 1", lat); end
        if (res_x !== 8'd7) begin miscompares++; $display("FAIL wri_res: got %h want 07", res_x); end
        if (done_rd !== 3'd1) begin miscompares++; $display("FAIL wri_rd: got %0d want 1", done_rd); end
        issue(2'd0, 3'd2, 3'd0, 3'd0, 8'd6);
        wait_done(lat);
        dbg_addr = 3'd3;
        issue(2'd2, 3'd3, 3'd1, 3'd2, 8'd0);
        wait_done(lat);
        vectors += 7;
        if (lat != 9) begin miscompares++; $display("FAIL mul_latency: got %0d want 9", lat); end
        if (done_rd !== 3'd3) begin miscompares++; $display("FAIL mul_rd: got %0d want 3", done_rd); end
        if (res_x !== 8'd42) begin miscompares++; $display("FAIL mul_res: got %0d want 42", res_x); end
        if (op_a !== 8'd7) begin miscompares++; $display("FAIL mul_op_a: got %0d want 7", op_a); end
        if (op_b !== 8'd6) begin miscompares++; $display("FAIL mul_op_b: got %0d want 6", op_b); end
        if (dbg_data !== 8'd0) begin miscompares++; $display("FAIL mul_dbg_old: got %0d want 0", dbg_data); end
        if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL mul_wb_ready: got %b want 0", cmd_ready); end
        @(negedge clk);
        vectors += 4;
        if (dbg_data !== 8'd42) begin miscompares++; $display("FAIL mul_dbg_new: got %0d want 42", dbg_data); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL mul_done_pulse: got %b want 0", done); end
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mul_ready_back: got %b want 1", cmd_ready); end
        if (res_x !== 8'd42) begin miscompares++; $display("FAIL mul_res_hold: got %0d want 42", res_x); end
    endtask

    task automatic test_trunc_wrap();
        int lat;
        issue(2'd0, 3'd1, 3'd0, 3'd0, 8'hFF);
        wait_done(lat);
        issue(2'd2, 3'd4, 3'd1, 3'd1, 8'd0);
        wait_done(lat);
        vectors += 3;
        if (lat != 9) begin miscompares++; $display("FAIL trunc_latency: got %0d want 9", lat); end
        if (res_x !== 8'h01) begin miscompares++; $display("FAIL trunc_res: got %h want 01", res_x); end
        if (op_a !== 8'hFF) begin miscompares++; $display("FAIL trunc_op_a: got %h want ff", op_a); end
        issue(2'd0, 3'd6, 3'd0, 3'd0, 8'hF0);
        wait_done(lat);
        issue(2'd0, 3'd7, 3'd0, 3'd0, 8'h20);
        wait_done(lat);
        dbg_addr = 3'd5;
        issue(2'd1, 3'd5, 3'd6, 3'd7, 8'h00);
        wait_done(lat);
        vectors += 5;
        if (lat != 1) begin miscompares++; $display("FAIL add_latency: got %0d want 1", lat); end
        if (res_x !== 8'h10) begin miscompares++; $display("FAIL add_wrap_res: got %h want 10", res_x); end
        if (done_rd !== 3'd5) begin miscompares++; $display("FAIL add_rd: got %0d want 5", done_rd); end
        if (op_b !== 8'h20) begin miscompares++; $display("FAIL add_op_b: got %h want 20", op_b); end
        @(negedge clk);
        if (dbg_data !== 8'h10) begin miscompares++; $display("FAIL add_dbg: got %h want 10", dbg_data); end
    endtask

    task automatic test_r0();
        int lat;
        issue(2'd0, 3'd0, 3'd0, 3'd0, 8'h55);
        wait_done(lat);
        vectors += 3;
        if (done !== 1'b1) begin miscompares++; $display("FAIL r0_done: got %b want 1", done); end
        if (done_rd !== 3'd0) begin miscompares++; $display("FAIL r0_rd: got %0d want 0", done_rd); end
        if (res_x !== 8'h55) begin miscompares++; $display("FAIL r0_res: got %h want 55", res_x); end
        dbg_addr = 3'd0;
        @(negedge clk);
        vectors++;
        if (dbg_data !== 8'h00) begin miscompares++; $display("FAIL r0_dbg: got %h want 00", dbg_data); end
        issue(2'd1, 3'd1, 3'd0, 3'd0, 8'h00);
        wait_done(lat);
        vectors += 2;
        if (res_x !== 8'h00) begin miscompares++; $display("FAIL r0_add_res: got %h want 00", res_x); end
        if (op_a !== 8'h00) begin miscompares++; $display("FAIL r0_add_op_a: got %h want 00", op_a); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]        b_op  [3];
        logic [AW-1:0]     b_rd  [3];
        logic [AW-1:0]     b_rs1 [3];
        logic [AW-1:0]     b_rs2 [3];
        logic [DATA_W-1:0] b_imm [3];
        logic [DATA_W-1:0] e_res [3];
        int                e_lat [3];
        int                acc_cyc [3];
        int cyc = 0;
        int idx = 0;
        int nd = 0;
        bit pend = 1'b0;
        b_op[0] = 2'd0; b_rd[0] = 3'd2; b_rs1[0] = 3'd0; b_rs2[0] = 3'd0; b_imm[0] = 8'd3;
        b_op[1] = 2'd2; b_rd[1] = 3'd3; b_rs1[1] = 3'd2; b_rs2[1] = 3'd2; b_imm[1] = 8'd0;
        b_op[2] = 2'd1; b_rd[2] = 3'd4; b_rs1[2] = 3'd3; b_rs2[2] = 3'd2; b_imm[2] = 8'd0;
        e_res[0] = 8'd3; e_res[1] = 8'd9; e_res[2] = 8'd12;
        e_lat[0] = 1;    e_lat[1] = 9;    e_lat[2] = 1;
        acc_cyc[0] = 0;  acc_cyc[1] = 0;  acc_cyc[2] = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = b_op[0]; cmd_rd = b_rd[0]; cmd_rs1 = b_rs1[0]; cmd_rs2 = b_rs2[0]; cmd_imm = b_imm[0];
        for (int k = 0; k < 40; k++) begin
            if (pend) begin
                pend = 1'b0;
                idx++;
                if (idx < 3) begin
                    cmd_op = b_op[idx]; cmd_rd = b_rd[idx]; cmd_rs1 = b_rs1[idx];
                    cmd_rs2 = b_rs2[idx]; cmd_imm = b_imm[idx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (done === 1'b1) begin
                vectors++;
                if (nd >= 3) begin
                    miscompares++;
                    $display("FAIL b2b_extra_done: done #%0d seen, want 3 total", nd + 1);
                end else begin
                    vectors += 3;
                    if (done_rd !== b_rd[nd]) begin miscompares++; $display("FAIL b2b_rd[%0d]: got %0d want %0d", nd, done_rd, b_rd[nd]); end
                    if (res_x !== e_res[nd]) begin miscompares++; $display("FAIL b2b_res[%0d]: got %0d want %0d", nd, res_x, e_res[nd]); end
                    if (cyc - acc_cyc[nd] != e_lat[nd]) begin miscompares++; $display("FAIL b2b_lat[%0d]: got %0d want %0d", nd, cyc - acc_cyc[nd], e_lat[nd]); end
                    if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_wb_ready[%0d]: got %b want 0", nd, cmd_ready); end
                end
                nd++;
            end
            if (cmd_valid && cmd_ready === 1'b1 && idx < 3) begin
                acc_cyc[idx] = cyc;
                pend = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        vectors++;
        if (nd != 3) begin miscompares++; $display("FAIL b2b_count: got %0d done pulses want 3", nd); end
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        int ndone = 0;
        issue(2'd0, 3'd1, 3'd0, 3'd0, 8'd3);
        wait_done(lat);
        issue(2'd0, 3'd2, 3'd0, 3'd0, 8'd4);
        wait_done(lat);
        issue(2'd2, 3'd3, 3'd1, 3'd2, 8'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors += 3;
        if (done !== 1'b0) begin miscompares++; $display("FAIL rstmul_done: got %b want 0", done); end
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rstmul_ready: got %b want 1", cmd_ready); end
        if (op_a !== 8'd0) begin miscompares++; $display("FAIL rstmul_op_a: got %0d want 0", op_a); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        vectors += 2;
        if (ndone != 0) begin miscompares++; $display("FAIL rstmul_no_done: got %0d pulses want 0", ndone); end
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rstmul_ready_after: got %b want 1", cmd_ready); end
        for (int i = 0; i < NREGS; i++) begin
            dbg_addr = AW'(i);
            #1;
            vectors++;
            if (dbg_data !== 8'd0) begin miscompares++; $display("FAIL rstmul_reg[%0d]: got %0d want 0", i, dbg_data); end
        end
        @(negedge clk);
    endtask

    task automatic test_self_mul_nop();
        int lat;
        issue(2'd0, 3'd2, 3'd0, 3'd0, 8'd5);
        wait_done(lat);
        dbg_addr = 3'd2;
        issue(2'd2, 3'd2, 3'd2, 3'd2, 8'd0);
        wait_done(lat);
        vectors += 5;
        if (lat != 9) begin miscompares++; $display("FAIL self_latency: got %0d want 9", lat); end
        if (res_x !== 8'd25) begin miscompares++; $display("FAIL self_res: got %0d want 25", res_x); end
        if (op_a !== 8'd5) begin miscompares++; $display("FAIL self_op_a: got %0d want 5", op_a); end
        if (op_b !== 8'd5) begin miscompares++; $display("FAIL self_op_b: got %0d want 5", op_b); end
        if (dbg_data !== 8'd5) begin miscompares++; $display("FAIL self_dbg_old: got %0d want 5", dbg_data); end
        @(negedge clk);
        vectors++;
        if (dbg_data !== 8'd25) begin miscompares++; $display("FAIL self_dbg_new: got %0d want 25", dbg_data); end
        issue(2'd3, 3'd2, 3'd2, 3'd2, 8'hAA);
        wait_done(lat);
        vectors += 3;
        if (lat != 1) begin miscompares++; $display("FAIL nop_latency: got %0d want 1", lat); end
        if (res_x !== 8'd0) begin miscompares++; $display("FAIL nop_res: got %0d want 0", res_x); end
        if (done_rd !== 3'd2) begin miscompares++; $display("FAIL nop_rd: got %0d want 2", done_rd); end
        @(negedge clk);
        vectors++;
        if (dbg_data !== 8'd25) begin miscompares++; $display("FAIL nop_no_write: got %0d want 25", dbg_data); end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_trunc_wrap();
        test_r0();
        test_back_to_back();
        test_reset_mid_mul();
        test_self_mul_nop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
